// File: rtl/mem_byte_bridge.sv
// mem_byte_bridge: serves 32-bit word read/write requests from a byte-wide synchronous RAM.
// Optional MEM_BRIDGE_SKIP_MASKED_EN: writes visit only the enabled bytes.
`default_nettype none

module mem_byte_bridge #(
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [1:0]            rw_flag,
  input  logic [31:0]           addr,
  input  logic [31:0]           write_data,
  input  logic [3:0]            write_mask,
  output logic [31:0]           read_data,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [7:0]            ram_wdata,
  output logic                  ram_we,
  input  logic [7:0]            ram_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;

  state_t                state, state_nxt;
  logic [2:0]            cnt, cnt_nxt;
  logic [ADDR_WIDTH-3:0] word, word_nxt;
  logic [31:0]           wdata_q, wdata_nxt;
  logic [3:0]            mask_q, mask_nxt;
  logic [23:0]           buf_q, buf_nxt;
  logic [31:0]           rdata_nxt;
  logic                  busy_nxt, done_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [7:0]            wbyte_nxt;
  logic                  we_q, we_nxt;
  logic [1:0]            slot;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^{addr[31:ADDR_WIDTH], addr[1:0]};

`ifdef MEM_BRIDGE_SKIP_MASKED_EN
  function automatic logic [1:0] first_set(input logic [3:0] m);
    if (m[0])      first_set = 2'd0;
    else if (m[1]) first_set = 2'd1;
    else if (m[2]) first_set = 2'd2;
    else           first_set = 2'd3;
  endfunction
`endif

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    word_nxt  = word;
    wdata_nxt = wdata_q;
    mask_nxt  = mask_q;
    buf_nxt   = buf_q;
    rdata_nxt = read_data;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    addr_nxt  = ram_addr;
    wbyte_nxt = ram_wdata;
    we_nxt    = 1'b0;
    slot      = 2'd0;
    unique case (state)
      S_IDLE: begin
        if (rw_flag != 2'b00) begin
          word_nxt  = addr[ADDR_WIDTH-1:2];
          wdata_nxt = write_data;
          mask_nxt  = write_mask;
          cnt_nxt   = 3'd0;
          busy_nxt  = 1'b1;
          addr_nxt  = {addr[ADDR_WIDTH-1:2], 2'd0};
          state_nxt = S_READ;
          // rw_flag[0] set means read, including the 2'b11 case
          if (!rw_flag[0]) begin
            state_nxt = S_WRITE;
`ifdef MEM_BRIDGE_SKIP_MASKED_EN
            if (write_mask == 4'b0000) begin
              state_nxt = S_IDLE;
              busy_nxt  = 1'b0;
              done_nxt  = 1'b1;
            end else begin
              slot      = first_set(write_mask);
              addr_nxt  = {addr[ADDR_WIDTH-1:2], slot};
              wbyte_nxt = write_data[{slot, 3'b000} +: 8];
              we_nxt    = 1'b1;
              mask_nxt  = write_mask & (write_mask - 4'd1);
            end
`else
            wbyte_nxt = write_data[7:0];
            we_nxt    = write_mask[0];
`endif
          end
        end
      end
      S_READ: begin
        cnt_nxt  = cnt + 3'd1;
        addr_nxt = {word, cnt[1:0] + 2'd1};
        // RAM data lags its address by one cycle, so slot cnt returns byte cnt-1
        case (cnt)
          3'd1: buf_nxt[7:0]   = ram_rdata;
          3'd2: buf_nxt[15:8]  = ram_rdata;
          3'd3: buf_nxt[23:16] = ram_rdata;
          3'd4: begin
            rdata_nxt = {ram_rdata, buf_q};
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = S_IDLE;
          end
          default: ;
        endcase
      end
      S_WRITE: begin
`ifdef MEM_BRIDGE_SKIP_MASKED_EN
        if (mask_q == 4'b0000) begin
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end else begin
          slot      = first_set(mask_q);
          addr_nxt  = {word, slot};
          wbyte_nxt = wdata_q[{slot, 3'b000} +: 8];
          we_nxt    = 1'b1;
          mask_nxt  = mask_q & (mask_q - 4'd1);
        end
`else
        if (cnt == 3'd3) begin
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt   = cnt + 3'd1;
          slot      = cnt[1:0] + 2'd1;
          addr_nxt  = {word, slot};
          wbyte_nxt = wdata_q[{slot, 3'b000} +: 8];
          we_nxt    = mask_q[slot];
        end
`endif
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt       <= 3'd0;
      word      <= '0;
      wdata_q   <= 32'd0;
      mask_q    <= 4'd0;
      buf_q     <= 24'd0;
      read_data <= 32'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= 8'd0;
      we_q      <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      word      <= word_nxt;
      wdata_q   <= wdata_nxt;
      mask_q    <= mask_nxt;
      buf_q     <= buf_nxt;
      read_data <= rdata_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      ram_addr  <= addr_nxt;
      ram_wdata <= wbyte_nxt;
      we_q      <= we_nxt;
    end
  end

  // A reset arriving mid-write must not let the pending byte commit at that same edge
  assign ram_we = we_q & ~RST;

endmodule

`default_nettype wire

// File: tb/tb_mem_byte_bridge.sv
// Scoreboard bench for mem_byte_bridge: directed scenarios followed by random word traffic.
`default_nettype none

module tb_mem_byte_bridge;
  localparam int AW  = 17;
  localparam int MSZ = 1 << AW;

  logic          CLK = 1'b0;
  logic          RST;
  logic [1:0]    rw_flag;
  logic [31:0]   addr, write_data, read_data;
  logic [3:0]    write_mask;
  logic          busy, done, ram_we;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdata, ram_rdata;

  mem_byte_bridge #(.ADDR_WIDTH(AW)) dut (
    .CLK(CLK), .RST(RST), .rw_flag(rw_flag), .addr(addr), .write_data(write_data),
    .write_mask(write_mask), .read_data(read_data), .busy(busy), .done(done),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic [7:0] mem    [MSZ];
  logic [7:0] shadow [MSZ];

  always @(posedge CLK) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  typedef struct packed {
    logic        is_read;
    logic [31:0] data;
    logic [31:0] c;
    logic [31:0] lat;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, expv);
    end
  endtask

  function automatic int write_latency(input logic [3:0] m);
`ifdef MEM_BRIDGE_SKIP_MASKED_EN
    return 1 + $countones(m);
`else
    return 5 + 0 * $countones(m);
`endif
  endfunction

  function automatic int word_base(input logic [31:0] a);
    return int'(a % 32'(MSZ)) / 4 * 4;
  endfunction

  // Called at a negedge with the bridge idle; returns #1 after the accepting edge
  task automatic issue(input logic [1:0] rw, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m);
    exp_t e;
    int   b;
    b         = word_base(a);
    e.is_read = (rw != 2'b10);
    e.c       = 32'(cyc);
    if (e.is_read) begin
      e.data = {shadow[b+3], shadow[b+2], shadow[b+1], shadow[b]};
      e.lat  = 32'd6;
    end else begin
      for (int k = 0; k < 4; k++)
        if (m[k]) shadow[b+k] = d[8*k +: 8];
      e.data = 32'd0;
      e.lat  = 32'(write_latency(m));
    end
    q.push_back(e);
    rw_flag = rw; addr = a; write_data = d; write_mask = m;
    @(posedge CLK);
    #1 rw_flag = 2'b00;
    check("busy_after_accept", {31'd0, busy},
          (!e.is_read && e.lat == 32'd1) ? 32'd0 : 32'd1);
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge CLK);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL done_timeout: got no done want done within 30 cycles");
    end
  endtask

  always @(negedge CLK) begin
    if (!RST && done) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done: got done=1 want no pending request");
      end else begin
        mon_e = q.pop_front();
        check("latency", 32'(cyc) - mon_e.c, mon_e.lat);
        if (mon_e.is_read) check("read_data", read_data, mon_e.data);
        check("busy_at_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  initial begin
    logic [7:0]  v;
    logic [7:0]  old1, old3;
    logic [31:0] rd;
    int          diffs;
    for (int i = 0; i < MSZ; i++) begin
      v = 8'($urandom);
      mem[i] = v; shadow[i] = v;
    end
    RST = 1'b1; rw_flag = 2'b00; addr = 32'd0; write_data = 32'd0; write_mask = 4'd0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_read_data", read_data, 32'd0);
    check("rst_ram_we", {31'd0, ram_we}, 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_wdata", {24'd0, ram_wdata}, 32'd0);
    RST = 1'b0;
    @(negedge CLK);

    // Word read of pre-loaded bytes
    mem[32'h104] = 8'h11; mem[32'h105] = 8'h22; mem[32'h106] = 8'h33; mem[32'h107] = 8'h44;
    shadow[32'h104] = 8'h11; shadow[32'h105] = 8'h22; shadow[32'h106] = 8'h33; shadow[32'h107] = 8'h44;
    issue(2'b01, 32'h0000_0104, 32'd0, 4'd0);
    wait_done();
    check("s1_word", read_data, 32'h4433_2211);

    // Partial write, then a read issued in its done cycle
    old1 = mem[32'h201]; old3 = mem[32'h203];
    issue(2'b10, 32'h0000_0200, 32'hAABB_CCDD, 4'b0101);
    wait_done();
    check("s2_byte0", {24'd0, mem[32'h200]}, 32'h0000_00DD);
    check("s2_byte1", {24'd0, mem[32'h201]}, {24'd0, old1});
    check("s2_byte2", {24'd0, mem[32'h202]}, 32'h0000_00BB);
    check("s2_byte3", {24'd0, mem[32'h203]}, {24'd0, old3});
    issue(2'b01, 32'h0000_0200, 32'd0, 4'd0);
    wait_done();

    // Request while busy is dropped
    old1 = mem[32'h2C0];
    issue(2'b10, 32'h0000_0280, 32'h1234_5678, 4'b1111);
    @(negedge CLK);
    rw_flag = 2'b10; addr = 32'h0000_02C0; write_data = 32'hDEAD_BEEF; write_mask = 4'b1111;
    @(posedge CLK);
    #1 rw_flag = 2'b00;
    wait_done();
    repeat (8) @(negedge CLK);
    check("s4_ignored", {24'd0, mem[32'h2C0]}, {24'd0, old1});

    // Reset in the third cycle of a full write
    old1 = mem[32'h301]; old3 = mem[32'h303]; v = mem[32'h302];
    rw_flag = 2'b10; addr = 32'h0000_0300; write_data = 32'h5566_7788; write_mask = 4'b1111;
    @(posedge CLK);
    #1 rw_flag = 2'b00;
    @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK);
    #1;
    check("s5_busy", {31'd0, busy}, 32'd0);
    check("s5_done", {31'd0, done}, 32'd0);
    check("s5_ram_we", {31'd0, ram_we}, 32'd0);
    check("s5_read_data", read_data, 32'd0);
    RST = 1'b0;
    check("s5_byte0", {24'd0, mem[32'h300]}, 32'h0000_0088);
    check("s5_byte1", {24'd0, mem[32'h301]}, {24'd0, old1});
    check("s5_byte2", {24'd0, mem[32'h302]}, {24'd0, v});
    check("s5_byte3", {24'd0, mem[32'h303]}, {24'd0, old3});
    shadow[32'h300] = 8'h88;
    @(negedge CLK);

    // High address bits wrap onto the RAM
    rd = {shadow[7], shadow[6], shadow[5], shadow[4]};
    issue(2'b01, 32'h0002_0004, 32'd0, 4'd0);
    wait_done();
    check("s6_wrap", read_data, rd);

    // Random traffic over a small window so reads observe earlier writes
    for (int n = 0; n < 200; n++) begin
      logic [1:0]  rw;
      logic [31:0] a;
      case ($urandom_range(0, 2))
        0:       rw = 2'b01;
        1:       rw = 2'b10;
        default: rw = 2'b11;
      endcase
      a = ($urandom & 32'hFFFE_0000) | 32'($urandom_range(0, 255));
      issue(rw, a, $urandom, 4'($urandom));
      wait_done();
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge CLK);
    end

    repeat (10) @(negedge CLK);
    check("queue_drained", 32'(q.size()), 32'd0);
    diffs = 0;
    for (int i = 0; i < MSZ; i++)
      if (mem[i] !== shadow[i]) diffs++;
    check("ram_image", 32'(diffs), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
